regfile_scoreboard: RTL and testbench

Parametrised integer register file with a built-in pending-write scoreboard, write-back bypass and a sequenced clear engine, for the pipelined RISC-V core. It sits between decode/issue and write-back. It supplies the rs1/rs2 operands, stalls issue on RAW/WAW hazards against in-flight writes, and can zero the whole file on request without a reset.

---
 rtl/regfile_scoreboard.sv | 68 ++++++
 tb/tb_regfile_scoreboard.sv | 127 ++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with pending-write scoreboard, write-back bypass and clear sweep
module regfile_scoreboard #(
  parameter int NUM_REG = 32,
  parameter int REG_WIDTH = 32,
  parameter int ADDR_W = $clog2(NUM_REG),
  parameter bit ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_req,
  output logic                 clr_busy,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rs1,
  input  logic [ADDR_W-1:0]    issue_rs2,
  input  logic [ADDR_W-1:0]    issue_rd,
  output logic                 issue_stall,
  output logic [REG_WIDTH-1:0] rs1_data,
  output logic [REG_WIDTH-1:0] rs2_data,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_rd,
  input  logic [REG_WIDTH-1:0] wb_data
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REG - 1);
  state_t state;
  logic [ADDR_W-1:0] idx;
  logic [REG_WIDTH-1:0] mem [NUM_REG];
  logic [NUM_REG-1:0] pending;
  logic idle, accept;
  // addresses past NUM_REG-1 (non power-of-two depth) behave like absent registers
  function automatic logic live(input logic [ADDR_W-1:0] a);
    return a <= LAST && !(ZERO_REG && a == '0);
  endfunction
  function automatic logic [REG_WIDTH-1:0] rd_port(input logic [ADDR_W-1:0] a);
    return !live(a) ? '0 : (wb_valid && idle && wb_rd == a) ? wb_data : mem[a];
  endfunction
  function automatic logic eff_pend(input logic [ADDR_W-1:0] a);
    return live(a) && pending[a] && !(wb_valid && idle && wb_rd == a);
  endfunction
  assign idle = state == IDLE;
  assign clr_busy = !idle;
  assign issue_stall = clr_busy || (issue_valid && (eff_pend(issue_rs1) || eff_pend(issue_rs2) || eff_pend(issue_rd)));
  assign accept = issue_valid && !issue_stall;
  assign rs1_data = rd_port(issue_rs1);
  assign rs2_data = rd_port(issue_rs2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      pending <= '0;
      for (int i = 0; i < NUM_REG; i++) mem[i] <= '0;
    end else if (clr_busy) begin
      mem[idx] <= '0;
      idx <= idx == LAST ? '0 : idx + ADDR_W'(1);
      state <= idx == LAST ? IDLE : CLEAR;
    end else begin
      if (wb_valid && live(wb_rd)) begin
        mem[wb_rd] <= wb_data;
        pending[wb_rd] <= 1'b0;
      end
      if (accept && live(issue_rd)) pending[issue_rd] <= 1'b1;
      if (clr_req) begin
        state <= CLEAR;
        idx <= '0;
        pending <= '0;
      end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of operands, bypass, hazards and clear sweep
module tb_regfile_scoreboard;
  logic clk = 0, rst_n = 0, clr_req = 0, issue_valid = 0, wb_valid = 0;
  logic [4:0] issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0, wb_rd = 0;
  logic [31:0] wb_data = 0, rs1_data, rs2_data;
  logic clr_busy, issue_stall;
  logic rst24_n = 0, clr24 = 0, busy24, stall24;
  logic [31:0] r1_24, r2_24;
  int passes = 0, fails = 0, checks = 0, ncyc;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(clr_busy),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_stall(issue_stall), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  regfile_scoreboard #(.NUM_REG(24)) dut24 (
    .clk(clk), .rst_n(rst24_n), .clr_req(clr24), .clr_busy(busy24),
    .issue_valid(1'b0), .issue_rs1(5'd0), .issue_rs2(5'd0), .issue_rd(5'd0),
    .issue_stall(stall24), .rs1_data(r1_24), .rs2_data(r2_24),
    .wb_valid(1'b0), .wb_rd(5'd0), .wb_data(32'd0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic wv, input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clk);
    issue_valid = iv; issue_rs1 = r1; issue_rs2 = r2; issue_rd = rd;
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1; rst24_n = 1;
    step(0, 5, 31, 0, 0, 0, 0);
    chk("reset_x5", rs1_data, 0);
    chk("reset_x31", rs2_data, 0);
    chk("reset_busy", 32'(clr_busy), 0);
    chk("reset_stall", 32'(issue_stall), 0);
    step(0, 3, 0, 0, 1, 3, 32'hDEADBEEF);
    chk("bypass_x3", rs1_data, 32'hDEADBEEF);
    step(0, 3, 0, 0, 0, 0, 0);
    chk("stored_x3", rs1_data, 32'hDEADBEEF);
    step(0, 0, 0, 0, 1, 0, 32'h1234);
    chk("x0_bypass", rs1_data, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("x0_stored", rs1_data, 0);
    step(1, 0, 0, 7, 0, 0, 0);
    chk("raw_issue", 32'(issue_stall), 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 7, 0, 0, 0, 0);
      chk("raw_stall", 32'(issue_stall), 1);
    end
    step(1, 0, 7, 0, 1, 7, 32'h55);
    chk("raw_resolve", 32'(issue_stall), 0);
    chk("raw_bypass", rs2_data, 32'h55);
    step(0, 0, 7, 0, 0, 0, 0);
    chk("x7_stored", rs2_data, 32'h55);
    step(1, 0, 0, 9, 0, 0, 0);
    chk("waw_issue", 32'(issue_stall), 0);
    step(1, 0, 0, 9, 0, 0, 0);
    chk("waw_stall", 32'(issue_stall), 1);
    step(1, 0, 0, 9, 1, 9, 32'hA);
    chk("waw_resolve", 32'(issue_stall), 0);
    step(1, 9, 0, 9, 0, 0, 0);
    chk("set_wins", 32'(issue_stall), 1);
    chk("x9_old_write", rs1_data, 32'hA);
    step(0, 0, 0, 0, 1, 9, 32'hB);
    step(1, 0, 0, 20, 0, 0, 0);
    chk("issue_x20", 32'(issue_stall), 0);
    for (int a = 1; a < 32; a++) step(0, 0, 0, 0, 1, 5'(a), 32'h1000 + a);
    step(0, 17, 31, 0, 0, 0, 0);
    chk("fill_x17", rs1_data, 32'h1011);
    chk("fill_x31", rs2_data, 32'h101F);
    @(negedge clk);
    clr_req = 1;
    #1 chk("busy_before_edge", 32'(clr_busy), 0);
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 12, 1, 5, 32'hFFFF);
      clr_req = 0;
      if (!clr_busy) break;
      ncyc++;
      chk("sweep_stall", 32'(issue_stall), 1);
    end
    chk("first_issue", 32'(issue_stall), 0);
    issue_valid = 0; wb_valid = 0;
    chk("sweep_len", ncyc, 32);
    for (int a = 0; a < 32; a++) begin
      step(1, 5'(a), 5'(a), 0, 0, 0, 0);
      chk("cleared_data", rs1_data, 0);
      chk("cleared_pend", 32'(issue_stall), 0);
    end
    issue_valid = 0;
    @(negedge clk) clr24 = 1;
    @(negedge clk) clr24 = 0;
    #1 chk("d24_busy_c1", 32'(busy24), 1);
    repeat (9) @(negedge clk);
    #1 chk("d24_busy_c10", 32'(busy24), 1);
    rst24_n = 0;
    #1 chk("d24_async_rst", 32'(busy24), 0);
    @(negedge clk) begin rst24_n = 1; clr24 = 1; end
    @(negedge clk) clr24 = 0;
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!busy24) break;
      ncyc++;
      @(negedge clk);
    end
    chk("d24_sweep_len", ncyc, 24);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
